// File: rtl/eb_fifo_ctrl_lvl.sv
// eb_fifo_ctrl_lvl: pointer, occupancy and flag controller for an elastic-buffer FIFO with external storage.
// Define EB_FIFO_CTRL_HWM_EN to add the high-water mark register and its hwm/hwm_clr ports.
module eb_fifo_ctrl_lvl #(
  parameter int DEPTH     = 16,
  parameter int PTRW      = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 1,
  parameter int FULL_RW   = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            t_0_req,
  output logic            t_0_ack,
  output logic            i_0_req,
  input  logic            i_0_ack,
  output logic            wen,
  output logic            ren,
  output logic [PTRW-1:0] wr_ptr,
  output logic [PTRW-1:0] rd_ptr,
  output logic [PTRW:0]   level,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
`ifdef EB_FIFO_CTRL_HWM_EN
  output logic [PTRW:0]   hwm,
  input  logic            hwm_clr,
`endif
  output logic            almost_empty
);

  localparam logic [PTRW:0]   LP_DEPTH   = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0]   LP_AFULL   = (PTRW+1)'(AFULL_TH);
  localparam logic [PTRW:0]   LP_AEMPTY  = (PTRW+1)'(AEMPTY_TH);
  localparam logic [PTRW-1:0] LP_PTR_MAX = PTRW'(DEPTH - 1);

  if (AFULL_TH > DEPTH || AEMPTY_TH >= DEPTH || DEPTH < 2 || DEPTH > (1 << PTRW)) begin : g_param_err
    $error("eb_fifo_ctrl_lvl: illegal DEPTH/PTRW/threshold parameter combination");
  end

  logic [PTRW-1:0] r_wr_ptr;
  logic [PTRW-1:0] r_rd_ptr;
  logic [PTRW:0]   r_level;
  logic [PTRW:0]   w_level_nxt;
  logic            w_full;
  logic            w_empty;
  logic            w_ireq;
  logic            w_tack;
  logic            w_wen;
  logic            w_ren;

  function automatic logic [PTRW-1:0] f_ptr_inc(input logic [PTRW-1:0] p);
    return (p == LP_PTR_MAX) ? '0 : p + PTRW'(1);
  endfunction

  assign w_full  = (r_level == LP_DEPTH);
  assign w_empty = (r_level == '0);
  assign w_ireq  = !w_empty && !flush;

  // FULL_RW=1 creates a combinational i_0_ack -> t_0_ack path; budget it in upstream timing.
  if (FULL_RW != 0) begin : g_full_rw
    assign w_tack = (!w_full || (w_ireq && i_0_ack)) && !flush;
  end else begin : g_no_full_rw
    assign w_tack = !w_full && !flush;
  end

  assign w_wen = t_0_req && w_tack;
  assign w_ren = w_ireq && i_0_ack;

  always_comb begin
    w_level_nxt = r_level;
    if (flush)
      w_level_nxt = '0;
    else if (w_wen && !w_ren)
      w_level_nxt = r_level + (PTRW+1)'(1);
    else if (!w_wen && w_ren)
      w_level_nxt = r_level - (PTRW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_level <= w_level_nxt;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wen) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
        if (w_ren) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
    end
  end

`ifdef EB_FIFO_CTRL_HWM_EN
  logic [PTRW:0] r_hwm;

  // Flush drives next level to 0, which never exceeds hwm, so flush leaves it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_hwm <= '0;
    else if (hwm_clr)
      r_hwm <= w_level_nxt;
    else if (w_level_nxt > r_hwm)
      r_hwm <= w_level_nxt;
  end

  assign hwm = r_hwm;
`endif

  assign t_0_ack      = w_tack;
  assign i_0_req      = w_ireq;
  assign wen          = w_wen;
  assign ren          = w_ren;
  assign wr_ptr       = r_wr_ptr;
  assign rd_ptr       = r_rd_ptr;
  assign level        = r_level;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_level >= LP_AFULL);
  assign almost_empty = (r_level <= LP_AEMPTY);

endmodule

// File: tb/tb_eb_fifo_ctrl_lvl.sv
// Directed bench for eb_fifo_ctrl_lvl: DEPTH=5 instances with FULL_RW=0 (a_*) and FULL_RW=1 (b_*).
// High-water mark checks run only when EB_FIFO_CTRL_HWM_EN is defined.
module tb_eb_fifo_ctrl_lvl;
  localparam int DEPTH = 5;
  localparam int PTRW  = 3;
  localparam int AF    = 4;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic reset_n, flush, t_0_req, i_0_ack;
  logic a_tack, a_ireq, a_wen, a_ren, a_full, a_empty, a_af, a_ae;
  logic b_tack, b_ireq, b_wen, b_ren, b_full, b_empty, b_af, b_ae;
  logic [PTRW-1:0] a_wr, a_rd, b_wr, b_rd;
  logic [PTRW:0]   a_lvl, b_lvl;
`ifdef EB_FIFO_CTRL_HWM_EN
  logic            hwm_clr;
  logic [PTRW:0]   a_hwm, b_hwm;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  eb_fifo_ctrl_lvl #(.DEPTH(DEPTH), .PTRW(PTRW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FULL_RW(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .t_0_req(t_0_req), .t_0_ack(a_tack),
    .i_0_req(a_ireq), .i_0_ack(i_0_ack), .wen(a_wen), .ren(a_ren), .wr_ptr(a_wr), .rd_ptr(a_rd),
    .level(a_lvl), .full(a_full), .empty(a_empty), .almost_full(a_af),
`ifdef EB_FIFO_CTRL_HWM_EN
    .hwm(a_hwm), .hwm_clr(hwm_clr),
`endif
    .almost_empty(a_ae));

  eb_fifo_ctrl_lvl #(.DEPTH(DEPTH), .PTRW(PTRW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FULL_RW(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .t_0_req(t_0_req), .t_0_ack(b_tack),
    .i_0_req(b_ireq), .i_0_ack(i_0_ack), .wen(b_wen), .ren(b_ren), .wr_ptr(b_wr), .rd_ptr(b_rd),
    .level(b_lvl), .full(b_full), .empty(b_empty), .almost_full(b_af),
`ifdef EB_FIFO_CTRL_HWM_EN
    .hwm(b_hwm), .hwm_clr(hwm_clr),
`endif
    .almost_empty(b_ae));

  typedef struct {
    logic req, ack, fl;
    logic e_tack0, e_tack1, e_wen, e_ren, e_ireq;
    int   e_lvl, e_wr, e_rd;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic req, input logic ack, input logic fl);
    @(negedge clk);
    t_0_req = req;
    i_0_ack = ack;
    flush   = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int lvl, input int wr, input int rd);
    chk({tag, " a.level"}, int'(a_lvl), lvl);
    chk({tag, " a.wr_ptr"}, int'(a_wr), wr);
    chk({tag, " a.rd_ptr"}, int'(a_rd), rd);
    chk({tag, " a.full"}, int'(a_full), int'(lvl == DEPTH));
    chk({tag, " a.empty"}, int'(a_empty), int'(lvl == 0));
    chk({tag, " a.almost_full"}, int'(a_af), int'(lvl >= AF));
    chk({tag, " a.almost_empty"}, int'(a_ae), int'(lvl <= AE));
  endtask

  task automatic chk_b(input string tag, input int lvl, input int wr, input int rd);
    chk({tag, " b.level"}, int'(b_lvl), lvl);
    chk({tag, " b.wr_ptr"}, int'(b_wr), wr);
    chk({tag, " b.rd_ptr"}, int'(b_rd), rd);
    chk({tag, " b.full"}, int'(b_full), int'(lvl == DEPTH));
    chk({tag, " b.empty"}, int'(b_empty), int'(lvl == 0));
    chk({tag, " b.almost_full"}, int'(b_af), int'(lvl >= AF));
    chk({tag, " b.almost_empty"}, int'(b_ae), int'(lvl <= AE));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_a(tag, 0, 0, 0);
    chk_b(tag, 0, 0, 0);
    chk({tag, " a.t_0_ack"}, int'(a_tack), 1);
    chk({tag, " b.t_0_ack"}, int'(b_tack), 1);
    chk({tag, " a.i_0_req"}, int'(a_ireq), 0);
    chk({tag, " b.i_0_req"}, int'(b_ireq), 0);
`ifdef EB_FIFO_CTRL_HWM_EN
    chk({tag, " a.hwm"}, int'(a_hwm), 0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    t_0_req = 1'b0;
    i_0_ack = 1'b0;
    flush   = 1'b0;
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m_wr, m_rd;
    reset_n = 1'b0;
    flush   = 1'b0;
    t_0_req = 1'b0;
    i_0_ack = 1'b0;
`ifdef EB_FIFO_CTRL_HWM_EN
    hwm_clr = 1'b0;
`endif

    // req ack fl | tack0 tack1 wen ren ireq | level wr rd (after edge)
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2, 2, 0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3, 3, 0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4, 4, 0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5, 0, 0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5, 0, 0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4, 0, 1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3, 0, 2};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2, 0, 3};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 0, 4};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2, 2, 0};

    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;

    // Fill to full, drain to empty, then settle at level 2
    for (int i = 0; i < 14; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].req, vecs[i].ack, vecs[i].fl);
      chk({tag, " a.t_0_ack"}, int'(a_tack), int'(vecs[i].e_tack0));
      chk({tag, " b.t_0_ack"}, int'(b_tack), int'(vecs[i].e_tack1));
      chk({tag, " a.wen"}, int'(a_wen), int'(vecs[i].e_wen));
      chk({tag, " a.ren"}, int'(a_ren), int'(vecs[i].e_ren));
      chk({tag, " a.i_0_req"}, int'(a_ireq), int'(vecs[i].e_ireq));
      chk({tag, " b.wen"}, int'(b_wen), int'(vecs[i].e_wen));
      chk({tag, " b.ren"}, int'(b_ren), int'(vecs[i].e_ren));
      tick();
      chk_a(tag, vecs[i].e_lvl, vecs[i].e_wr, vecs[i].e_rd);
      chk_b(tag, vecs[i].e_lvl, vecs[i].e_wr, vecs[i].e_rd);
    end

    // Streaming at level 2 for 20 cycles against a modulo pointer model
    m_wr = 2;
    m_rd = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      chk("stream a.wen", int'(a_wen), 1);
      chk("stream a.ren", int'(a_ren), 1);
      tick();
      m_wr = (m_wr + 1) % DEPTH;
      m_rd = (m_rd + 1) % DEPTH;
      chk_a("stream", 2, m_wr, m_rd);
      chk_b("stream", 2, m_wr, m_rd);
    end

    // Flush at level 3 with traffic requested on both sides
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
    end
    chk_a("preflush", 3, 3, 0);
    drive(1'b1, 1'b1, 1'b1);
    chk("flush a.wen", int'(a_wen), 0);
    chk("flush a.ren", int'(a_ren), 0);
    chk("flush a.t_0_ack", int'(a_tack), 0);
    chk("flush a.i_0_req", int'(a_ireq), 0);
    chk("flush b.t_0_ack", int'(b_tack), 0);
    chk("flush b.ren", int'(b_ren), 0);
    tick();
    chk_a("postflush", 0, 0, 0);
    chk_b("postflush", 0, 0, 0);

    // Full with simultaneous write and read: FULL_RW=0 vs FULL_RW=1
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
    end
    chk_a("fill5", 5, 0, 0);
    chk_b("fill5", 5, 0, 0);
    drive(1'b1, 1'b1, 1'b0);
    chk("fullrw a.t_0_ack", int'(a_tack), 0);
    chk("fullrw a.wen", int'(a_wen), 0);
    chk("fullrw a.ren", int'(a_ren), 1);
    chk("fullrw b.t_0_ack", int'(b_tack), 1);
    chk("fullrw b.wen", int'(b_wen), 1);
    chk("fullrw b.ren", int'(b_ren), 1);
    tick();
    chk_a("fullrw", 4, 0, 1);
    chk_b("fullrw", 5, 1, 1);

    // Asynchronous reset mid-run clears state without a clock edge
    drive(1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;

`ifdef EB_FIFO_CTRL_HWM_EN
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
    end
    chk_a("hwm fill4", 4, 4, 0);
    chk("hwm fill4 a.hwm", int'(a_hwm), 4);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      tick();
    end
    chk_a("hwm drain", 1, 4, 3);
    chk("hwm drain a.hwm", int'(a_hwm), 4);
    drive(1'b0, 1'b0, 1'b0);
    hwm_clr = 1'b1;
    tick();
    chk("hwm clr a.hwm", int'(a_hwm), 1);
    drive(1'b0, 1'b0, 1'b1);
    hwm_clr = 1'b0;
    tick();
    chk("hwm flush a.hwm", int'(a_hwm), 1);
    chk_a("hwm flush", 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("hwm reset a.hwm", int'(a_hwm), 0);
    @(negedge clk);
    reset_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eb_fifo_ctrl_lvl.md
Name: eb_fifo_ctrl_lvl

Overview:
Parametrised FIFO controller for elastic-buffer pipelines. It manages write/read pointers, occupancy and status flags for an external register-file or flop-array storage that has a synchronous write and a combinational read. This generation of the controller supports:
- any depth, including non-power-of-two
- a synchronous flush
- almost-full and almost-empty thresholds
- an optional pass-through on full
It sits between an upstream t_0 req/ack producer and a downstream i_0 req/ack consumer.

Parameters:
- DEPTH, 16, number of entries; legal range 2..1024, need not be a power of 2.
- PTRW, 4, pointer width; DEPTH must be <= 2**PTRW.
- AFULL_TH, 14, almost_full asserts when level >= AFULL_TH.
- AEMPTY_TH, 1, almost_empty asserts when level <= AEMPTY_TH.
- FULL_RW, 0, when 1, a write is accepted while full if a read completes in the same cycle.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all FIFO state.
- t_0_req  in  1  upstream has a write pending.
- t_0_ack  out  1  controller accepts the write.
- i_0_req  out  1  head entry is valid.
- i_0_ack  in  1  downstream consumes the head entry.
- wen  out  1  storage write enable, at address wr_ptr.
- ren  out  1  read-complete strobe.
- wr_ptr  out  PTRW  next write address.
- rd_ptr  out  PTRW  head read address.
- level  out  PTRW+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AFULL_TH.
- almost_empty  out  1  level <= AEMPTY_TH.
- hwm  out  PTRW+1  high-water mark (EB_FIFO_CTRL_HWM_EN only).
- hwm_clr  in  1  clears hwm (EB_FIFO_CTRL_HWM_EN only).

Behaviour:
- State registers: wr_ptr, rd_ptr, level (and hwm when enabled).
  - The async reset (reset_n low) clears all of them to 0.
  - All flags are decoded combinationally from level.
  - Reset outputs: empty=1, almost_empty=1, full=0, almost_full=0 (given legal thresholds), i_0_req=0, t_0_ack=1.
- i_0_req = !empty && !flush.
- t_0_ack:
  - FULL_RW=0: (!full) && !flush.
  - FULL_RW=1: (!full || (i_0_req && i_0_ack)) && !flush. This makes a combinational i_0_ack -> t_0_ack path, which is documented for timing.
- wen = t_0_req && t_0_ack; ren = i_0_req && i_0_ack.
- Pointer update:
  - On wen, wr_ptr advances; on ren, rd_ptr advances.
  - Wrap rule: a pointer equal to DEPTH-1 goes to 0, otherwise +1. A pointer never takes a value >= DEPTH.
- Level update:
  - wen only: level+1; ren only: level-1; both or neither: unchanged.
  - level never exceeds DEPTH and never underflows, guaranteed by the ack and req gating.
- Latency:
  - A write accepted in cycle N raises i_0_req in cycle N+1 (zero-cycle bypass is not supported).
  - A read in cycle N deasserts full in cycle N+1 (or same-cycle acceptance when FULL_RW=1).
- Data at rd_ptr is valid whenever i_0_req=1. Storage must not be written at rd_ptr while the FIFO is non-empty; pointer math guarantees this.
- flush:
  - Has priority over all traffic.
  - In the flush cycle wen=0, ren=0, t_0_ack=0, i_0_req=0.
  - Next edge: wr_ptr=rd_ptr=level=0. hwm is not affected.
- Simultaneous wen and ren when level==0: impossible, since i_0_req=0.
- Simultaneous wen and ren when level==DEPTH: only possible with FULL_RW=1; level stays at DEPTH and both pointers advance.
- Reset mid-operation: immediate clear of all state; in-flight handshakes are discarded.
- Threshold legality: elaboration must error if AFULL_TH > DEPTH or AEMPTY_TH >= DEPTH (via a generate-time check).

Optional Feature:
Macro EB_FIFO_CTRL_HWM_EN.
- Defined:
  - hwm is a register tracking the maximum level reached: hwm <= max(hwm, next level) each cycle.
  - hwm_clr loads hwm with the current next level.
  - hwm resets to 0 and is unaffected by flush.
- Undefined: hwm and hwm_clr ports are absent and no logic is generated.

Test Plan:
1. DEPTH=5, PTRW=3, FULL_RW=0: write 5 with no reads -> level=5, full=1, t_0_ack=0, wr_ptr wraps 4->0.
2. Then read 5 with t_0_req=0 -> rd_ptr sequence 0,1,2,3,4,0; empty=1 and i_0_req=0 after the 5th ren.
3. Steady streaming at level=2, wen and ren every cycle for 20 cycles -> level held at 2; pointers stay in 0..4 and match the golden model.
4. FULL_RW=1, level=5, t_0_req=1, i_0_ack=1 -> t_0_ack=1, wen=ren=1, level stays 5; with FULL_RW=0 the same stimulus gives t_0_ack=0 and level 4 next cycle.
5. level=3, pointers at 3 and 0, assert flush with t_0_req=i_0_ack=1 -> wen=ren=0 in that cycle; next cycle level=0, pointers 0, empty=1.
6. HWM_EN defined, AFULL_TH=4: fill to 4 -> almost_full=1, hwm=4; drain to 1 -> almost_empty=1, hwm=4; hwm_clr at level 1 -> hwm=1. Mid-run reset_n low -> all outputs at reset values immediately.
